// File: rtl/led_pattern_gen_if.sv
// Bus between a controller and the LED pattern generator: run controls
// flow toward the generator, the registered pattern and step strobe flow back.
interface led_pattern_gen_if #(
  parameter int N_LED = 4,
  parameter int DIV_W = 24
) ();
  logic             start;
  logic [1:0]       mode;
  logic [DIV_W-1:0] period;
  logic [N_LED-1:0] led;
  logic             step_pulse;

  modport master (
    output start,
    output mode,
    output period,
    input  led,
    input  step_pulse
  );

  modport slave (
    input  start,
    input  mode,
    input  period,
    output led,
    output step_pulse
  );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler produces step ticks every period+1
// cycles while running, and each tick advances a bounce, rotate-up,
// rotate-down or blink-all pattern. The first tick after reset only primes
// the outputs so the sequence starts from LED 0 (or all-on when blinking).
module led_pattern_gen #(
  parameter int N_LED = 4,
  parameter int DIV_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  led_pattern_gen_if.slave  bus
);

  localparam int POS_W = (N_LED > 2) ? $clog2(N_LED) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic {
    UNPRIMED = 1'b0,
    PRIMED   = 1'b1
  } prime_state_e;

  prime_state_e     prime_q, prime_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             phase_q, phase_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             pulse_q, pulse_d;
  logic             tick;

  // Greater-or-equal lets a shortened period take effect on the very next
  // running edge instead of waiting for the counter to wrap.
  assign tick = bus.start && (cnt_q >= bus.period);

  // Next-state logic: prescaler, pattern position/direction, blink phase and
  // the LED image of the state that results from this tick.
  always_comb begin
    prime_d = prime_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    led_d   = led_q;
    pulse_d = 1'b0;

    if (bus.start) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    if (tick) begin
      pulse_d = 1'b1;
      if (prime_q == UNPRIMED) begin
        prime_d = PRIMED;
        phase_d = (bus.mode == 2'd3);
      end else begin
        phase_d = 1'b0;
        unique case (bus.mode)
          2'd0: begin
            if (!dir_q) begin
              if (pos_q == LAST_POS) begin
                pos_d = LAST_POS - POS_ONE;
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q + POS_ONE;
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = POS_ONE;
                dir_d = 1'b0;
              end else begin
                pos_d = pos_q - POS_ONE;
              end
            end
          end
          2'd1: begin
            pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_ONE;
            dir_d = 1'b0;
          end
          2'd2: begin
            pos_d = (pos_q == '0) ? LAST_POS : pos_q - POS_ONE;
            dir_d = 1'b1;
          end
          default: begin
            phase_d = ~phase_q;
          end
        endcase
      end

      if (bus.mode == 2'd3) begin
        led_d = {N_LED{phase_d}};
      end else begin
        led_d = N_LED'(1) << pos_d;
      end
    end
  end

  // State register; reset clears everything and forces a fresh priming tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_q <= UNPRIMED;
      cnt_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      phase_q <= 1'b0;
      led_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      prime_q <= prime_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen with four LEDs: a table of directed vectors,
// hand-written freeze/period-change/reset sequences, then randomized
// traffic compared with an arithmetic reference model.
module tb_led_pattern_gen;
  localparam int N_LED = 4;
  localparam int DIV_W = 24;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  led_pattern_gen_if #(.N_LED(N_LED), .DIV_W(DIV_W)) bus ();

  led_pattern_gen #(.N_LED(N_LED), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integers, one call per rising edge.
  int         mCnt, mPos, mDir, mPhase, mPrimed;
  logic [3:0] mLed;
  logic       mPulse;

  task automatic modelEdge();
    int np;
    int stepDir;
    if (reset) begin
      mCnt = 0; mPos = 0; mDir = 0; mPhase = 0; mPrimed = 0;
      mLed = '0; mPulse = 1'b0;
      return;
    end
    mPulse = 1'b0;
    if (!bus.start) return;
    if (mCnt < int'(bus.period)) begin
      mCnt = mCnt + 1;
      return;
    end
    mCnt = 0;
    mPulse = 1'b1;
    if (mPrimed == 0) begin
      mPrimed = 1;
      mPhase = (bus.mode == 2'd3) ? 1 : 0;
    end else begin
      case (bus.mode)
        2'd0: begin
          stepDir = (mDir == 0) ? 1 : -1;
          np = mPos + stepDir;
          if (np < 0 || np > N_LED - 1) begin
            mDir = 1 - mDir;
            np = mPos - stepDir;
          end
          mPos = np;
          mPhase = 0;
        end
        2'd1: begin mPos = (mPos + 1) % N_LED; mDir = 0; mPhase = 0; end
        2'd2: begin mPos = (mPos + N_LED - 1) % N_LED; mDir = 1; mPhase = 0; end
        default: mPhase = 1 - mPhase;
      endcase
    end
    if (bus.mode == 2'd3) mLed = (mPhase != 0) ? 4'b1111 : 4'b0000;
    else                  mLed = 4'b0001 << mPos;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [1:0] m,
                               input logic [DIV_W-1:0] p);
    reset      = r;
    bus.start  = s;
    bus.mode   = m;
    bus.period = p;
  endtask

  // One rising edge, model update, then settle before sampling.
  task automatic stepClock();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expLed,
                             input logic expPulse);
    checks++;
    if (bus.led !== expLed) begin
      errors++;
      $display("[TB] FAIL %s led got=%b want=%b", name, bus.led, expLed);
    end
    checks++;
    if (bus.step_pulse !== expPulse) begin
      errors++;
      $display("[TB] FAIL %s step_pulse got=%b want=%b", name, bus.step_pulse, expPulse);
    end
  endtask

  typedef struct {
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [DIV_W-1:0] period;
    logic [3:0]       expLed;
    logic             expPulse;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic s, input logic [1:0] m,
                        input int p, input logic [3:0] l, input logic sp);
    vec_t v;
    v.rst = r; v.start = s; v.mode = m; v.period = DIV_W'(p);
    v.expLed = l; v.expPulse = sp;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mCnt = 0; mPos = 0; mDir = 0; mPhase = 0; mPrimed = 0;
    mLed = '0; mPulse = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd0, '0);

    // Bounce at full speed, including both turnarounds.
    addVec(1, 1, 0, 0, 4'b0000, 0);
    addVec(0, 1, 0, 0, 4'b0001, 1);
    addVec(0, 1, 0, 0, 4'b0010, 1);
    addVec(0, 1, 0, 0, 4'b0100, 1);
    addVec(0, 1, 0, 0, 4'b1000, 1);
    addVec(0, 1, 0, 0, 4'b0100, 1);
    addVec(0, 1, 0, 0, 4'b0010, 1);
    addVec(0, 1, 0, 0, 4'b0001, 1);
    addVec(0, 1, 0, 0, 4'b0010, 1);
    // Bounce with a three-cycle step interval.
    addVec(1, 1, 0, 2, 4'b0000, 0);
    addVec(0, 1, 0, 2, 4'b0000, 0);
    addVec(0, 1, 0, 2, 4'b0000, 0);
    addVec(0, 1, 0, 2, 4'b0001, 1);
    addVec(0, 1, 0, 2, 4'b0001, 0);
    addVec(0, 1, 0, 2, 4'b0001, 0);
    addVec(0, 1, 0, 2, 4'b0010, 1);
    addVec(0, 1, 0, 2, 4'b0010, 0);
    addVec(0, 1, 0, 2, 4'b0010, 0);
    addVec(0, 1, 0, 2, 4'b0100, 1);
    // Rotate up with wrap.
    addVec(1, 1, 1, 0, 4'b0000, 0);
    addVec(0, 1, 1, 0, 4'b0001, 1);
    addVec(0, 1, 1, 0, 4'b0010, 1);
    addVec(0, 1, 1, 0, 4'b0100, 1);
    addVec(0, 1, 1, 0, 4'b1000, 1);
    addVec(0, 1, 1, 0, 4'b0001, 1);
    // Rotate down with wrap.
    addVec(1, 1, 2, 0, 4'b0000, 0);
    addVec(0, 1, 2, 0, 4'b0001, 1);
    addVec(0, 1, 2, 0, 4'b1000, 1);
    addVec(0, 1, 2, 0, 4'b0100, 1);
    addVec(0, 1, 2, 0, 4'b0010, 1);
    addVec(0, 1, 2, 0, 4'b0001, 1);
    // Blink, then switch to bounce from pos 0 going up.
    addVec(1, 1, 3, 0, 4'b0000, 0);
    addVec(0, 1, 3, 0, 4'b1111, 1);
    addVec(0, 1, 3, 0, 4'b0000, 1);
    addVec(0, 1, 3, 0, 4'b1111, 1);
    addVec(0, 1, 0, 0, 4'b0010, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].mode, vecs[i].period);
      stepClock();
      checkOutput($sformatf("vec%0d", i), vecs[i].expLed, vecs[i].expPulse);
    end

    // Freeze at cnt=3 with period 5, resume, then shorten the period.
    applyStimulus(1, 1, 1, 5); stepClock(); checkOutput("frz_reset", 4'b0000, 0);
    applyStimulus(0, 1, 1, 5);
    for (int i = 0; i < 3; i++) stepClock();
    applyStimulus(0, 0, 1, 5);
    for (int i = 0; i < 10; i++) begin
      stepClock();
      checkOutput($sformatf("frz_hold%0d", i), 4'b0000, 0);
    end
    applyStimulus(0, 1, 1, 5);
    stepClock(); checkOutput("frz_res1", 4'b0000, 0);
    stepClock(); checkOutput("frz_res2", 4'b0000, 0);
    stepClock(); checkOutput("frz_res3", 4'b0001, 1);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput($sformatf("frz_cnt%0d", i), 4'b0001, 0);
    end
    applyStimulus(0, 1, 1, 1);
    stepClock(); checkOutput("period_drop", 4'b0010, 1);

    // Reset mid-run with start held high, then a fresh priming tick.
    applyStimulus(1, 1, 1, 0); stepClock();
    applyStimulus(0, 1, 1, 0);
    stepClock(); stepClock(); stepClock();
    checkOutput("mid_pre", 4'b0100, 1);
    applyStimulus(1, 1, 1, 0); stepClock(); checkOutput("mid_reset", 4'b0000, 0);
    applyStimulus(0, 1, 1, 0); stepClock(); checkOutput("mid_prime", 4'b0001, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 8),
                    2'($urandom_range(0, 3)), DIV_W'($urandom_range(0, 3)));
      stepClock();
      checkOutput($sformatf("rand%0d", i), mLed, mPulse);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter N_LED, default 4, number of LEDs driven (legal range 2..32).
REQ-002 Parameter DIV_W, default 24, width of the step-period prescaler.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; dominates every other input.
REQ-005 start  input  1  run enable; 1 = prescaler counts and pattern advances, 0 = freeze.
REQ-006 mode  input  2  pattern select: 0 bounce, 1 rotate-up, 2 rotate-down, 3 blink-all.
REQ-007 period  input  DIV_W  step interval minus one, in clk cycles (0 = step every cycle).
REQ-008 led  output  N_LED  registered LED pattern.
REQ-009 step_pulse  output  1  registered one-cycle strobe, high in the cycle a new led value first appears.

Function
REQ-010 Internal state SHALL be: prescaler cnt (DIV_W), position pos (max(1,clog2(N_LED)) bits), direction dir (0 up, 1 down), blink phase, and primed flag.
REQ-011 A step tick SHALL occur on an edge where start=1 and cnt >= period; on that edge cnt <= 0, else cnt <= cnt+1 while start=1.
REQ-012 Comparison SHALL be >= so that lowering period below the current cnt produces a tick on the next start=1 edge (no wrap-around wait).
REQ-013 With start=0, cnt, pos, dir, phase, primed and led SHALL hold; step_pulse SHALL be 0.
REQ-014 mode SHALL be sampled only on tick edges; changes between ticks have no effect until the next tick.
REQ-015 First tick after reset (primed=0): pos, dir unchanged, primed <= 1, phase <= 1 if mode=3 else 0, led loaded from resulting state.
REQ-016 Subsequent ticks, mode 0 (bounce): dir=0 and pos<N_LED-1 -> pos+1; dir=0 and pos=N_LED-1 -> pos=N_LED-2, dir=1; dir=1 and pos>0 -> pos-1; dir=1 and pos=0 -> pos=1, dir=0; endpoints never repeated.
REQ-017 Mode 1 (rotate-up): pos <= pos+1, N_LED-1 wraps to 0; dir <= 0.
REQ-018 Mode 2 (rotate-down): pos <= pos-1, 0 wraps to N_LED-1; dir <= 1.
REQ-019 Mode 3 (blink): pos, dir held; phase <= ~phase.
REQ-020 In modes 0-2 phase SHALL be cleared to 0 on the tick.
REQ-021 On every tick led SHALL load the pattern of the next state: one-hot of next pos in modes 0-2, all bits = next phase in mode 3; led never changes on non-tick edges.
REQ-022 step_pulse SHALL be 1 in exactly the cycle after each tick edge, 0 otherwise; back-to-back ticks (period=0) give a continuously high step_pulse.
REQ-023 No combinational path from any input to led or step_pulse.
REQ-024 pos SHALL never exceed N_LED-1 for any non-power-of-two N_LED.

Reset
REQ-025 reset=1 at an edge SHALL set cnt=0, pos=0, dir=0, phase=0, primed=0, led=0, step_pulse=0 regardless of start, mode, period.
REQ-026 Reset asserted mid-sequence SHALL discard the sequence; next run begins with a priming tick (REQ-015).

Verification (N_LED=4)
REQ-027 reset, then start=1, mode=0, period=0 -> led per cycle 0001,0010,0100,1000,0100,0010,0001,0010; step_pulse continuously 1.
REQ-028 mode=0, period=2 -> led changes every 3rd cycle, step_pulse high 1 cycle of every 3, coincident with each change.
REQ-029 mode=1 from reset -> 0001,0010,0100,1000,0001; mode=2 from reset -> 0001,1000,0100,0010,0001.
REQ-030 mode=3 from reset -> 1111,0000,1111; mode switched to 0 mid-blink with pos=0, dir=0 -> next tick led=0010, phase=0.
REQ-031 period=5 with start dropped at cnt=3 for 10 cycles -> led, cnt frozen, step_pulse 0; start restored -> tick after exactly 3 more cycles; period changed to 1 while cnt=4 -> tick on next edge.
REQ-032 reset pulsed with start=1 at led=0100 -> next cycle led=0000, step_pulse=0; run resumes with led=0001 on first tick.
